// File: rtl/debounce_sync.sv
// Debouncer for a raw asynchronous bit: N-flop synchronizer followed by a
// two-state stability counter; emits a clean level plus rise/fall pulses.
module debounce_sync #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [0:0] ST_STABLE = 1'b0;
    localparam logic [0:0] ST_CHECK  = 1'b1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [0:0]             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_dout;
    logic                   r_rise;
    logic                   r_fall;

    logic                   w_s;
    logic [0:0]             w_state_nx;
    logic [CNT_W-1:0]       w_cnt_nx;
    logic                   w_dout_nx;
    logic                   w_rise_nx;
    logic                   w_fall_nx;

    // Plain flop chain; nothing may sit between stages for metastability settling.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_sync <= '0;
        else          r_sync <= {r_sync[SYNC_STAGES-2:0], din};
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_dout_nx  = r_dout;
        w_rise_nx  = 1'b0;
        w_fall_nx  = 1'b0;
        case (r_state)
            ST_STABLE: begin
                if (w_s != r_dout) begin
                    w_state_nx = ST_CHECK;
                    w_cnt_nx   = CNT_ONE;
                end else begin
                    w_cnt_nx   = '0;
                end
            end
            ST_CHECK: begin
                if (w_s == r_dout) begin
                    w_state_nx = ST_STABLE;
                    w_cnt_nx   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    // Mismatch held for the full window: commit the new level.
                    w_state_nx = ST_STABLE;
                    w_cnt_nx   = '0;
                    w_dout_nx  = ~r_dout;
                    w_rise_nx  = ~r_dout;
                    w_fall_nx  = r_dout;
                end else begin
                    w_cnt_nx   = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nx = ST_STABLE;
                w_cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_STABLE;
            r_cnt   <= '0;
            r_dout  <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_dout  <= w_dout_nx;
            r_rise  <= w_rise_nx;
            r_fall  <= w_fall_nx;
        end
    end

    assign dout = r_dout;
    assign rise = r_rise;
    assign fall = r_fall;
    assign busy = (r_state == ST_CHECK);

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: directed scenarios plus random bounce, checked
// against a run-length reference ("s differs from dout for N samples in a row").
module tb_debounce_sync;

    localparam int SYNC = 2;
    localparam int STAB = 4;
    localparam int LAT  = SYNC + STAB - 1;

    logic clk = 1'b0;
    logic reset_n;
    logic din;
    logic dout, rise, fall, busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    debounce_sync #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(STAB)) dut (
        .clk(clk), .reset_n(reset_n), .din(din),
        .dout(dout), .rise(rise), .fall(fall), .busy(busy)
    );

    // Reference: din delayed SYNC samples, then a run length of mismatches.
    logic [SYNC-1:0] m_dly;
    int              m_run;
    logic            m_dout, m_rise, m_fall;
    logic [3:0]      exp_v, got_v;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_dly  <= '0;
            m_run  <= 0;
            m_dout <= 1'b0;
            m_rise <= 1'b0;
            m_fall <= 1'b0;
        end else begin
            m_dly  <= {m_dly[SYNC-2:0], din};
            m_rise <= 1'b0;
            m_fall <= 1'b0;
            if (m_dly[SYNC-1] == m_dout) begin
                m_run <= 0;
            end else if (m_run + 1 == STAB) begin
                m_run  <= 0;
                m_dout <= ~m_dout;
                m_rise <= ~m_dout;
                m_fall <= m_dout;
            end else begin
                m_run <= m_run + 1;
            end
        end
    end

    assign exp_v = {m_dout, m_rise, m_fall, (m_run != 0)};
    assign got_v = {dout, rise, fall, busy};

    task automatic test_reset;
        logic [3:0] want;
        reset_n = 1'b0;
        din     = 1'b1;
        #3;
        n_cmp++;
        if (got_v !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_hold_early got dout/rise/fall/busy=%b want 0000", got_v);
        end
        @(negedge clk);
        n_cmp++;
        if (got_v !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_hold_edge got %b want 0000", got_v);
        end
        #2 reset_n = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            want = {(j >= LAT + 1), (j == LAT + 1), 1'b0, (j >= SYNC + 1 && j <= LAT)};
            n_cmp++;
            if (got_v !== want) begin
                n_err++;
                $display("FAIL reset_release edge %0d got %b want %b", j, got_v, want);
            end
        end
    endtask

    task automatic test_clean_fall;
        logic [3:0] want;
        @(negedge clk);
        #2 din = 1'b0;
        for (int j = 1; j <= 9; j++) begin
            @(negedge clk);
            want = {(j <= LAT), 1'b0, (j == LAT + 1), (j >= SYNC + 1 && j <= LAT)};
            n_cmp++;
            if (got_v !== want) begin
                n_err++;
                $display("FAIL clean_fall edge %0d got %b want %b", j, got_v, want);
            end
            n_cmp++;
            if (got_v !== exp_v) begin
                n_err++;
                $display("FAIL clean_fall_model edge %0d got %b want %b", j, got_v, exp_v);
            end
        end
    endtask

    task automatic test_clean_rise;
        logic [3:0] want;
        @(negedge clk);
        #2 din = 1'b1;
        for (int j = 1; j <= 9; j++) begin
            @(negedge clk);
            want = {(j > LAT), (j == LAT + 1), 1'b0, (j >= SYNC + 1 && j <= LAT)};
            n_cmp++;
            if (got_v !== want) begin
                n_err++;
                $display("FAIL clean_rise edge %0d got %b want %b", j, got_v, want);
            end
        end
    endtask

    task automatic test_glitch;
        logic seen_busy = 1'b0;
        int   pulses    = 0;
        @(negedge clk);
        #2 din = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            if (busy) seen_busy = 1'b1;
            if (rise || fall) pulses++;
            n_cmp++;
            if (got_v !== exp_v) begin
                n_err++;
                $display("FAIL glitch_model edge %0d got %b want %b", j, got_v, exp_v);
            end
            if (j == 2) #2 din = 1'b0;
        end
        n_cmp++;
        if (!(seen_busy === 1'b1 && pulses == 0 && dout === 1'b0 && busy === 1'b0)) begin
            n_err++;
            $display("FAIL glitch_summary got busy_seen=%b pulses=%0d dout=%b busy=%b want 1 0 0 0",
                     seen_busy, pulses, dout, busy);
        end
    endtask

    task automatic test_bounce;
        int rises = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_cmp++;
            if (dout !== 1'b0 || rise !== 1'b0) begin
                n_err++;
                $display("FAIL bounce_burst cyc %0d got dout=%b rise=%b want 0 0", i, dout, rise);
            end
            #2 din = ~din;
        end
        @(negedge clk);
        #2 din = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            if (rise) rises++;
            n_cmp++;
            if (rise !== (j == LAT + 1)) begin
                n_err++;
                $display("FAIL bounce_settle edge %0d got rise=%b want %b", j, rise, (j == LAT + 1));
            end
        end
        n_cmp++;
        if (rises != 1 || dout !== 1'b1) begin
            n_err++;
            $display("FAIL bounce_count got rises=%0d dout=%b want 1 1", rises, dout);
        end
    endtask

    task automatic test_reset_mid_check;
        int pulses = 0;
        @(negedge clk);
        #2 din = 1'b0;
        for (int c = 0; c < 12 && !busy; c++) @(posedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_wait got busy=%b want 1 (timeout)", busy);
        end
        #3 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (got_v !== 4'b0000) begin
            n_err++;
            $display("FAIL midreset_async got %b want 0000", got_v);
        end
        @(negedge clk);
        #2 reset_n = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            if (rise || fall) pulses++;
        end
        n_cmp++;
        if (pulses != 0 || dout !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_after got pulses=%0d dout=%b want 0 0", pulses, dout);
        end
    endtask

    task automatic test_random;
        int hold;
        for (int i = 0; i < 300; i++) begin
            hold = $urandom_range(1, 7);
            din  = 1'($urandom);
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                n_cmp++;
                if (got_v !== exp_v || (rise && fall)) begin
                    n_err++;
                    $display("FAIL random it %0d got %b want %b", i, got_v, exp_v);
                end
            end
            #2;
        end
    endtask

    initial begin
        test_reset();
        test_clean_fall();
        test_clean_rise();
        test_clean_fall();
        test_glitch();
        test_bounce();
        test_reset_mid_check();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
